// File: rtl/btn_scan_pkg.sv
// Shared FSM encodings, control bundle and default parameters for the button scanner.
// Pure declarations: no latency, no flow control.
package btn_scan_pkg;

  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_FIFO_DEPTH      = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_COMMIT   = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic adv;
    logic cnt_clr;
    logic cnt_inc;
    logic commit;
  } scan_ctl_t;

endpackage

// File: rtl/btn_evt_fifo.sv
// Press-event queue; head visible combinationally, push lands 1 cycle later.
// Full queue accepts a push only alongside a pop; pop on empty is ignored.
module btn_evt_fifo
  import btn_scan_pkg::*;
#(
  parameter int DW    = 2,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_en;
  logic          rd_en;

  // Extra pointer bit separates full from empty when the slot indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en    = pop & ~empty;
  assign wr_en    = push & (~full | pop);
  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Debounces NUM_BTN buttons with one shared counter scanned round-robin; press events go to a FIFO.
// Level change after sync+scan+DEBOUNCE_CYCLES+1 cycles; evt_valid/evt_id hold until evt_ready, overflow pulses on drop.
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         raw_btn,
  output logic [NUM_BTN-1:0]         btn_state,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic                       evt_overflow
);

  localparam int             IDW      = $clog2(NUM_BTN);
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync;
  scan_state_t        state;
  scan_state_t        state_nxt;
  scan_ctl_t          ctl;
  logic [IDW-1:0]     idx;
  logic [CW-1:0]      cnt;
  logic               differ;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;

  assign differ = sync[idx] ^ btn_state[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN:     if (differ) state_nxt = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (!differ)              state_nxt = ST_SCAN;
        else if (cnt == CNT_LAST) state_nxt = ST_COMMIT;
      end
      ST_COMMIT:   state_nxt = ST_SCAN;
      default:     state_nxt = ST_SCAN;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      ST_SCAN: begin
        if (differ) ctl.cnt_clr = 1'b1;
        else        ctl.adv     = 1'b1;
      end
      ST_DEBOUNCE: begin
        if (differ) ctl.cnt_inc = 1'b1;
        else        ctl.adv     = 1'b1;
      end
      ST_COMMIT: begin
        ctl.commit = 1'b1;
        ctl.adv    = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Only a 0->1 commit is a press; releases update the level silently.
  assign push = ctl.commit & ~btn_state[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta    <= '0;
      sync         <= '0;
      btn_state    <= '0;
      idx          <= '0;
      cnt          <= '0;
      evt_overflow <= 1'b0;
    end else begin
      sync_meta <= raw_btn;
      sync      <= sync_meta;
      if (ctl.adv)         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (ctl.cnt_clr)     cnt <= '0;
      else if (ctl.cnt_inc) cnt <= cnt + 1'b1;
      if (ctl.commit)      btn_state[idx] <= ~btn_state[idx];
      // A full queue is never empty, so evt_ready alone decides whether room frees up.
      evt_overflow <= push & fifo_full & ~evt_ready;
    end
  end

  btn_evt_fifo #(
    .DW    (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (idx),
    .pop      (evt_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (evt_id)
  );

  assign evt_valid = ~fifo_empty;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl: directed presses push expected ids, a monitor pops on handshakes.
module tb_btn_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw_btn = '0;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready = 1'b0;
  logic       evt_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_evt    = 0;
  int n_ovf    = 0;

  logic [1:0] exp_q[$];
  logic       hold_prev = 1'b0;
  logic [1:0] id_prev = '0;

  btn_scan_ctrl #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (16),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_btn      (raw_btn),
    .btn_state    (btn_state),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", {evt_valid, evt_id}, {1'b1, id_prev});
      if (evt_overflow) n_ovf++;
      if (evt_valid && evt_ready) begin
        n_evt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL evt_spurious: got id %0d, expected no event", evt_id);
        end else begin
          chk("evt_order", evt_id, exp_q.pop_front());
        end
      end
      hold_prev = evt_valid && !evt_ready;
      id_prev   = evt_id;
    end
  end

  task automatic reset_pulse(input logic [3:0] raw_during);
    @(negedge clk);
    rst_n   = 1'b0;
    raw_btn = raw_during;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // After release idx equals (edges since release) mod 4, so driving after the 2nd edge
  // makes the synchronised change visible exactly when idx is 0.
  task automatic press_from_reset(input logic [3:0] mask);
    reset_pulse(4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    raw_btn = mask;
  endtask

  task automatic wait_btn(input int b, input logic v, input int max, output int n);
    n = 0;
    while (n <= max) begin
      @(posedge clk);
      #1;
      n++;
      if (btn_state[b] === v) break;
    end
  endtask

  initial begin
    int n;
    int base;
    int base_ovf;
    logic [3:0] seen;

    repeat (3) @(negedge clk);
    chk("rst_btn_state", btn_state, 4'h0);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_evt_id", evt_id, 2'd0);
    chk("rst_evt_overflow", evt_overflow, 1'b0);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Single press: 2 sync + up to 4 scan + 16 debounce + 1 commit edges.
    base = n_evt;
    raw_btn[2] = 1'b1;
    exp_q.push_back(2'd2);
    wait_btn(2, 1'b1, 23, n);
    chk_range("press_latency", n, 20, 23);
    chk("press_evt_valid", evt_valid, 1'b1);
    chk("press_evt_id", evt_id, 2'd2);
    repeat (40) @(negedge clk);
    chk("press_single_evt", n_evt - base, 1);

    // Release: level falls with the same timing, no event.
    base = n_evt;
    raw_btn[2] = 1'b0;
    wait_btn(2, 1'b0, 23, n);
    chk_range("release_latency", n, 20, 23);
    repeat (30) @(negedge clk);
    chk("release_no_evt", n_evt - base, 0);

    // 8-cycle glitch is rejected.
    base     = n_evt;
    base_ovf = n_ovf;
    seen     = '0;
    raw_btn[1] = 1'b1;
    repeat (8) @(negedge clk);
    raw_btn[1] = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= btn_state;
    end
    chk("glitch_btn_state", seen, 4'h0);
    chk("glitch_no_evt", n_evt - base, 0);
    chk("glitch_no_ovf", n_ovf - base_ovf, 0);

    // Simultaneous presses queue in scan order 0, 1, 3.
    evt_ready = 1'b0;
    press_from_reset(4'b1011);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    repeat (100) @(negedge clk);
    chk("multi_state", btn_state, 4'b1011);
    chk("multi_head_valid", evt_valid, 1'b1);
    chk("multi_head_id", evt_id, 2'd0);
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("multi_drained", exp_q.size(), 0);
    chk("multi_empty", evt_valid, 1'b0);

    // Five presses into a depth-4 queue: fifth is dropped with one overflow pulse.
    evt_ready = 1'b0;
    press_from_reset(4'b0111);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    base_ovf = n_ovf;
    repeat (80) @(negedge clk);
    raw_btn[0] = 1'b0;
    repeat (30) @(negedge clk);
    raw_btn[0] = 1'b1;
    exp_q.push_back(2'd0);
    repeat (30) @(negedge clk);
    raw_btn[0] = 1'b0;
    repeat (30) @(negedge clk);
    raw_btn[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("ovf_pulses", n_ovf - base_ovf, 1);
    chk("ovf_valid", evt_valid, 1'b1);
    chk("ovf_head_id", evt_id, 2'd0);
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("ovf_drained", exp_q.size(), 0);

    // Reset in the middle of a debounce, then the held button starts over.
    raw_btn[3] = 1'b1;
    repeat (14) @(negedge clk);
    chk("mid_db_state", btn_state, 4'b0111);
    rst_n   = 1'b0;
    raw_btn = 4'b1000;
    exp_q.delete();
    #1;
    chk("arst_btn_state", btn_state, 4'h0);
    chk("arst_evt_valid", evt_valid, 1'b0);
    chk("arst_evt_id", evt_id, 2'd0);
    chk("arst_evt_overflow", evt_overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(2'd3);
    wait_btn(3, 1'b1, 30, n);
    chk_range("afresh_latency", n, 21, 21);
    repeat (10) @(negedge clk);
    chk("afresh_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected test completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/btn_scan_ctrl.md
BTN_SCAN_CTRL -- requirements
Module: btn_scan_ctrl

Interface
REQ-001 Parameter NUM_BTN, default 4: number of raw button inputs scheduled by the block.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable mismatch cycles needed to accept a level change (range 2..255).
REQ-003 Parameter FIFO_DEPTH, default 4: press-event queue depth (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 raw_btn  input  NUM_BTN  unsynchronised mechanical button levels, 1 = pressed.
REQ-007 btn_state  output  NUM_BTN  debounced level per button.
REQ-008 evt_valid  output  1  press event available at the queue head.
REQ-009 evt_id  output  clog2(NUM_BTN)  index of the button at the queue head; valid only while evt_valid = 1.
REQ-010 evt_ready  input  1  consumer accepts the head event when evt_valid & evt_ready.
REQ-011 evt_overflow  output  1  one-cycle pulse when a press event is dropped because the queue is full.

Function
REQ-012 Each raw_btn bit SHALL pass through a 2-flop synchroniser (sync); the debounce logic SHALL use only sync.
REQ-013 A single shared debounce counter SHALL be time-multiplexed across buttons by a scan index idx, starting at 0.
REQ-014 The FSM SHALL have states SCAN, DEBOUNCE and COMMIT.
REQ-015 SCAN: if sync[idx] == btn_state[idx], idx advances by 1 (wrapping NUM_BTN-1 -> 0) and the FSM stays in SCAN; otherwise, the counter clears to 0 and the FSM goes to DEBOUNCE with idx held.
REQ-016 DEBOUNCE, while sync[idx] != btn_state[idx]: the counter increments each cycle; at count == DEBOUNCE_CYCLES-1 the FSM goes to COMMIT, so DEBOUNCE lasts exactly DEBOUNCE_CYCLES cycles.
REQ-017 DEBOUNCE, if sync[idx] == btn_state[idx] on any cycle: abort, leave btn_state unchanged, advance idx and return to SCAN.
REQ-018 COMMIT (1 cycle): btn_state[idx] toggles at the end of the cycle; on a 0->1 change, push idx into the queue; a 1->0 change produces no event; then advance idx and go to SCAN.
REQ-019 A push accepted in COMMIT SHALL make evt_valid = 1 on the next cycle.
REQ-020 The queue SHALL be FIFO-ordered; evt_id and evt_valid SHALL remain stable while evt_valid & !evt_ready.
REQ-021 A push to a full queue SHALL be accepted if a pop occurs in the same cycle; otherwise, the event is dropped and evt_overflow pulses for 1 cycle.
REQ-022 A pop on an empty queue SHALL have no effect.
REQ-023 Simultaneous push and pop on a non-empty, non-full queue SHALL leave the occupancy unchanged.
REQ-024 Worst-case latency from a stable sync change to the btn_state update SHALL be NUM_BTN-1 + 1 + DEBOUNCE_CYCLES + 1 cycles, with a bounded scan (no starvation).

Reset
REQ-025 When rst_n = 0, all of the following SHALL be cleared asynchronously: sync, btn_state = 0, idx = 0, counter = 0, FSM = SCAN, queue empty, evt_valid = 0, evt_id = 0, evt_overflow = 0.
REQ-026 Reset asserted mid-DEBOUNCE or mid-COMMIT SHALL discard the in-flight change and any queued events.
REQ-027 Reset release SHALL require no further initialisation.

Structure
REQ-028 The FSM state encodings and the default parameter constants SHALL live in the shared package btn_scan_pkg.
REQ-029 The event queue SHALL be the sub-module btn_evt_fifo, which provides push/pop, full/empty and simultaneous-push/pop handling.
REQ-030 The counter width SHALL be clog2(DEBOUNCE_CYCLES).

Verification
REQ-031 With defaults, hold raw_btn[2] = 1 from cycle 10 -> btn_state[2] rises and evt_valid = 1 with evt_id = 2, each within 2+4+16+1 cycles; exactly one event is produced.
REQ-032 Pulse raw_btn[1] high for 8 cycles -> btn_state stays 0, no event, evt_overflow stays 0.
REQ-033 Press buttons 0, 1 and 3 simultaneously with evt_ready = 0 -> three events queued in scan order 0, 1, 3; then set evt_ready = 1 -> they drain in that order.
REQ-034 Hold evt_ready = 0 and commit 5 presses -> the first 4 are queued and evt_overflow pulses once on the 5th.
REQ-035 Assert rst_n = 0 at DEBOUNCE count 10 -> all outputs read 0 immediately; after release, the held button debounces afresh from count 0.
REQ-036 Release a pressed button (1->0) -> btn_state falls after DEBOUNCE_CYCLES and no event is generated.
